// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-2 stream demultiplexer.
// Each beat is routed by sel into one of two 2-entry channel FIFOs
// (index 1 = true channel, index 0 = false channel). Each channel also
// keeps a count of the beats accepted into it.
module demux_stream #(
    parameter int unsigned BUS   = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BUS-1:0]   data_in,
    input  logic             sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [BUS-1:0]   data_true,
    output logic             valid_true,
    input  logic             ready_true,
    output logic [BUS-1:0]   data_false,
    output logic             valid_false,
    input  logic             ready_false,
    output logic [CNT_W-1:0] cnt_true,
    output logic [CNT_W-1:0] cnt_false
);

    localparam int unsigned NCH   = 2;
    localparam int unsigned OCC_W = 2;

    logic [NCH-1:0]            full_c;
    logic [NCH-1:0]            push_c;
    logic [NCH-1:0]            pop_c;
    logic [NCH-1:0]            rdy_c;
    logic [NCH-1:0]            valid_c;
    logic [NCH-1:0][BUS-1:0]   head_c;
    logic [NCH-1:0][CNT_W-1:0] cnt_c;

    // Input acceptance. push/pop depend only on registered state and
    // handshake inputs; in_valid gates push, so sel is ignored while idle.
    always_comb begin
        rdy_c     = {ready_true, ready_false};
        in_ready  = sel ? !full_c[1] : !full_c[0];
        push_c[1] = in_valid & sel & ~full_c[1];
        push_c[0] = in_valid & ~sel & ~full_c[0];
        pop_c     = valid_c & rdy_c;
    end

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        logic [BUS-1:0]   mem_q [2];
        logic [BUS-1:0]   mem_d [2];
        logic             wptr_q, wptr_d;
        logic             rptr_q, rptr_d;
        logic [OCC_W-1:0] occ_q, occ_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // Channel FIFO and counter next-state.
        always_comb begin
            mem_d  = mem_q;
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            occ_d  = occ_q;
            cnt_d  = cnt_q;
            if (push_c[ch]) begin
                mem_d[wptr_q] = data_in;
                wptr_d        = ~wptr_q;
                cnt_d         = cnt_q + CNT_W'(1);
            end
            if (pop_c[ch]) begin
                rptr_d = ~rptr_q;
            end
            case ({push_c[ch], pop_c[ch]})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end

        // Channel state registers; reset discards any buffered beats.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem_q[0] <= '0;
                mem_q[1] <= '0;
                wptr_q   <= 1'b0;
                rptr_q   <= 1'b0;
                occ_q    <= '0;
                cnt_q    <= '0;
            end else begin
                mem_q    <= mem_d;
                wptr_q   <= wptr_d;
                rptr_q   <= rptr_d;
                occ_q    <= occ_d;
                cnt_q    <= cnt_d;
            end
        end

        assign full_c[ch]  = (occ_q == OCC_W'(2));
        assign valid_c[ch] = (occ_q != OCC_W'(0));
        assign head_c[ch]  = mem_q[rptr_q];
        assign cnt_c[ch]   = cnt_q;
    end

    assign data_true   = head_c[1];
    assign valid_true  = valid_c[1];
    assign cnt_true    = cnt_c[1];
    assign data_false  = head_c[0];
    assign valid_false = valid_c[0];
    assign cnt_false   = cnt_c[0];

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: directed and scoreboarded checks of demux_stream.
// u_dut uses the default counter width; u_wrap (CNT_W=4) shares the
// same inputs and is used for the counter wrap scenario.
module tb_demux_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data_in;
    logic        sel;
    logic        in_valid;
    logic        ready_true;
    logic        ready_false;

    logic        in_ready;
    logic [31:0] data_true, data_false;
    logic        valid_true, valid_false;
    logic [15:0] cnt_true, cnt_false;

    logic        w_in_ready;
    logic [31:0] w_data_true, w_data_false;
    logic        w_valid_true, w_valid_false;
    logic [3:0]  w_cnt_true, w_cnt_false;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    demux_stream #(.BUS(32), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_true(data_true), .valid_true(valid_true), .ready_true(ready_true),
        .data_false(data_false), .valid_false(valid_false), .ready_false(ready_false),
        .cnt_true(cnt_true), .cnt_false(cnt_false)
    );

    demux_stream #(.BUS(32), .CNT_W(4)) u_wrap (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .sel(sel),
        .in_valid(in_valid), .in_ready(w_in_ready),
        .data_true(w_data_true), .valid_true(w_valid_true), .ready_true(ready_true),
        .data_false(w_data_false), .valid_false(w_valid_false), .ready_false(ready_false),
        .cnt_true(w_cnt_true), .cnt_false(w_cnt_false)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        rst_n    = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; sel = 1'b0; data_in = '0;
        ready_true = 1'b0; ready_false = 1'b0;
        cyc(); cyc();
        checks++;
        if (valid_true !== 1'b0 || valid_false !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid: got %b/%b expected 0/0", valid_true, valid_false);
        end
        checks++;
        if (cnt_true !== 16'd0 || cnt_false !== 16'd0) begin
            failures++;
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cnt_true, cnt_false);
        end
        sel = 1'b0; #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_rdy_sel0: got %b expected 1", in_ready);
        end
        sel = 1'b1; #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_rdy_sel1: got %b expected 1", in_ready);
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        ready_true = 1'b1; ready_false = 1'b0;
        sel = 1'b1; data_in = 32'hA5A5_0001; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_rdy: got %b expected 1", in_ready);
        end
        cyc();
        in_valid = 1'b0; #1;
        checks++;
        if (valid_true !== 1'b1 || data_true !== 32'hA5A5_0001) begin
            failures++;
            $display("FAIL single_out: got v=%b d=%h expected v=1 d=a5a50001", valid_true, data_true);
        end
        checks++;
        if (valid_false !== 1'b0) begin
            failures++;
            $display("FAIL single_false_idle: got %b expected 0", valid_false);
        end
        checks++;
        if (cnt_true !== 16'd1 || cnt_false !== 16'd0) begin
            failures++;
            $display("FAIL single_cnt: got %0d/%0d expected 1/0", cnt_true, cnt_false);
        end
        cyc();
        checks++;
        if (valid_true !== 1'b0) begin
            failures++;
            $display("FAIL single_one_cycle: got %b expected 0", valid_true);
        end
    endtask

    task automatic test_backpressure();
        ready_true = 1'b0; ready_false = 1'b0;
        sel = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            data_in = 32'h10 + 32'(i); #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL bp_accept%0d: got %b expected 1", i, in_ready);
            end
            cyc();
        end
        data_in = 32'h12; #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_full: got %b expected 0", in_ready);
        end
        cyc();
        ready_false = 1'b1; #1;
        checks++;
        if (in_ready !== 1'b0 || data_false !== 32'h10 || valid_false !== 1'b1) begin
            failures++;
            $display("FAIL bp_head0: got rdy=%b v=%b d=%h expected rdy=0 v=1 d=10", in_ready, valid_false, data_false);
        end
        cyc();
        checks++;
        if (in_ready !== 1'b1 || data_false !== 32'h11 || valid_false !== 1'b1) begin
            failures++;
            $display("FAIL bp_head1: got rdy=%b v=%b d=%h expected rdy=1 v=1 d=11", in_ready, valid_false, data_false);
        end
        cyc();
        in_valid = 1'b0; #1;
        checks++;
        if (valid_false !== 1'b1 || data_false !== 32'h12) begin
            failures++;
            $display("FAIL bp_head2: got v=%b d=%h expected v=1 d=12", valid_false, data_false);
        end
        checks++;
        if (cnt_false !== 16'd3) begin
            failures++;
            $display("FAIL bp_cnt: got %0d expected 3", cnt_false);
        end
        cyc();
        checks++;
        if (valid_false !== 1'b0) begin
            failures++;
            $display("FAIL bp_drained: got %b expected 0", valid_false);
        end
        ready_false = 1'b0;
    endtask

    task automatic test_independent();
        ready_false = 1'b0; ready_true = 1'b1;
        sel = 1'b0; in_valid = 1'b1;
        data_in = 32'h30; cyc();
        data_in = 32'h31; cyc();
        for (int i = 0; i < 8; i++) begin
            sel = 1'b1; data_in = 32'h20 + 32'(i); in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL indep_rdy%0d: got %b expected 1", i, in_ready);
            end
            if (i > 0) begin
                checks++;
                if (valid_true !== 1'b1 || data_true !== 32'h20 + 32'(i - 1)) begin
                    failures++;
                    $display("FAIL indep_out%0d: got v=%b d=%h expected v=1 d=%h",
                             i - 1, valid_true, data_true, 32'h20 + 32'(i - 1));
                end
            end
            cyc();
        end
        in_valid = 1'b0; #1;
        checks++;
        if (valid_true !== 1'b1 || data_true !== 32'h27) begin
            failures++;
            $display("FAIL indep_out7: got v=%b d=%h expected v=1 d=27", valid_true, data_true);
        end
        checks++;
        if (cnt_true !== 16'd9 || cnt_false !== 16'd5) begin
            failures++;
            $display("FAIL indep_cnt: got %0d/%0d expected 9/5", cnt_true, cnt_false);
        end
        checks++;
        if (valid_false !== 1'b1 || data_false !== 32'h30) begin
            failures++;
            $display("FAIL indep_false_head: got v=%b d=%h expected v=1 d=30", valid_false, data_false);
        end
        ready_false = 1'b1;
        cyc();
        checks++;
        if (valid_false !== 1'b1 || data_false !== 32'h31 || valid_true !== 1'b0) begin
            failures++;
            $display("FAIL indep_false_next: got vf=%b d=%h vt=%b expected vf=1 d=31 vt=0",
                     valid_false, data_false, valid_true);
        end
        cyc();
        checks++;
        if (valid_false !== 1'b0) begin
            failures++;
            $display("FAIL indep_false_drained: got %b expected 0", valid_false);
        end
        ready_false = 1'b0; ready_true = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] q_t[$];
        logic [31:0] q_f[$];
        int          n_t, n_f, accepted, cycles;
        logic        exp_rdy, do_push, pop_t, pop_f, s;
        logic [31:0] d;
        do_reset();
        n_t = 0; n_f = 0; accepted = 0; cycles = 0;
        while (accepted < 2000 && cycles < 20000) begin
            in_valid    = 1'($urandom_range(0, 3) != 0);
            sel         = 1'($urandom_range(0, 1));
            ready_true  = 1'($urandom_range(0, 2) != 0);
            ready_false = 1'($urandom_range(0, 2) != 0);
            data_in     = $urandom;
            #1;
            exp_rdy = sel ? (q_t.size() < 2) : (q_f.size() < 2);
            checks++;
            if (in_ready !== exp_rdy) begin
                failures++;
                $display("FAIL rnd_rdy c%0d: got %b expected %b", cycles, in_ready, exp_rdy);
            end
            checks++;
            if (valid_true !== (q_t.size() != 0) ||
                (q_t.size() != 0 && data_true !== q_t[0])) begin
                failures++;
                $display("FAIL rnd_true c%0d: got v=%b d=%h expected v=%b d=%h", cycles,
                         valid_true, data_true, q_t.size() != 0, (q_t.size() != 0) ? q_t[0] : 32'h0);
            end
            checks++;
            if (valid_false !== (q_f.size() != 0) ||
                (q_f.size() != 0 && data_false !== q_f[0])) begin
                failures++;
                $display("FAIL rnd_false c%0d: got v=%b d=%h expected v=%b d=%h", cycles,
                         valid_false, data_false, q_f.size() != 0, (q_f.size() != 0) ? q_f[0] : 32'h0);
            end
            do_push = in_valid && exp_rdy;
            pop_t   = (q_t.size() != 0) && ready_true;
            pop_f   = (q_f.size() != 0) && ready_false;
            s = sel; d = data_in;
            cyc();
            if (pop_t) void'(q_t.pop_front());
            if (pop_f) void'(q_f.pop_front());
            if (do_push) begin
                accepted++;
                if (s) begin q_t.push_back(d); n_t++; end
                else   begin q_f.push_back(d); n_f++; end
            end
            cycles++;
        end
        in_valid = 1'b0;
        checks++;
        if (accepted < 2000) begin
            failures++;
            $display("FAIL rnd_timeout: got %0d beats expected 2000", accepted);
        end
        #1;
        checks++;
        if (cnt_true !== 16'(n_t) || cnt_false !== 16'(n_f)) begin
            failures++;
            $display("FAIL rnd_cnt: got %0d/%0d expected %0d/%0d", cnt_true, cnt_false, n_t, n_f);
        end
        ready_true = 1'b1; ready_false = 1'b1;
        cyc(); cyc();
    endtask

    task automatic test_wrap();
        do_reset();
        ready_true = 1'b1; ready_false = 1'b0;
        sel = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            data_in = 32'(i);
            cyc();
            if (i == 15) begin
                checks++;
                if (w_cnt_true !== 4'd15) begin
                    failures++;
                    $display("FAIL wrap15: got %0d expected 15", w_cnt_true);
                end
            end else if (i == 16) begin
                checks++;
                if (w_cnt_true !== 4'd0) begin
                    failures++;
                    $display("FAIL wrap16: got %0d expected 0", w_cnt_true);
                end
            end else if (i == 17) begin
                checks++;
                if (w_cnt_true !== 4'd1 || cnt_true !== 16'd17) begin
                    failures++;
                    $display("FAIL wrap17: got %0d/%0d expected 1/17", w_cnt_true, cnt_true);
                end
            end
        end
        in_valid = 1'b0;
        cyc(); cyc();
    endtask

    task automatic test_reset_mid();
        do_reset();
        ready_true = 1'b0; ready_false = 1'b0; in_valid = 1'b1;
        sel = 1'b1; data_in = 32'h40; cyc();
        data_in = 32'h41; cyc();
        sel = 1'b0; data_in = 32'h50; cyc();
        data_in = 32'h51; cyc();
        in_valid = 1'b0; #1;
        checks++;
        if (valid_true !== 1'b1 || valid_false !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_full: got vt=%b vf=%b rdy=%b expected 1 1 0", valid_true, valid_false, in_ready);
        end
        rst_n = 1'b0; #1;
        checks++;
        if (valid_true !== 1'b0 || valid_false !== 1'b0) begin
            failures++;
            $display("FAIL mid_async_valid: got %b/%b expected 0/0", valid_true, valid_false);
        end
        checks++;
        if (cnt_true !== 16'd0 || cnt_false !== 16'd0) begin
            failures++;
            $display("FAIL mid_async_cnt: got %0d/%0d expected 0/0", cnt_true, cnt_false);
        end
        rst_n = 1'b1; #1;
        sel = 1'b0; #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_rdy_sel0: got %b expected 1", in_ready);
        end
        sel = 1'b1; #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_rdy_sel1: got %b expected 1", in_ready);
        end
        ready_true = 1'b1; ready_false = 1'b1; sel = 1'bx;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (valid_true !== 1'b0 || valid_false !== 1'b0 ||
                cnt_true !== 16'd0 || cnt_false !== 16'd0) begin
                failures++;
                $display("FAIL mid_stale%0d: got vt=%b vf=%b ct=%0d cf=%0d expected 0 0 0 0",
                         i, valid_true, valid_false, cnt_true, cnt_false);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_independent();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
